dpram_bus_master: RTL and testbench

//  Synchronous host-side controller for one port of the DS1609-style dual-port RAM,

---
 rtl/dpram_bus_master.sv | 235 +++++++++++++++++++++++
 tb/tb_dpram_bus_master.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_bus_master.sv
// -----------------------------------------------------------------------------
// dpram_bus_master
//
// Host-side controller for one port of a DS1609-style dual-port RAM with a
// multiplexed address/data bus. A single-beat read or write is accepted over a
// valid/ready handshake. The controller then sequences the RAM pins through an
// address phase, a data phase and a recovery phase, and reports completion
// with a one-cycle response pulse. Read data is presented with that pulse.
//
// The AD pad is built outside this module:
//     AD = ad_oe ? ad_o : 'bz;   ad_i = AD;
//
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       controller idle; accept on req_valid & req_ready
//   req_we     in   1       1 = write, 0 = read
//   req_addr   in   ADDR_W  RAM address
//   req_wdata  in   DATA_W  write data
//   rsp_valid  out  1       one-cycle pulse at the end of every access
//   rsp_rdata  out  DATA_W  read data; valid with rsp_valid after a read
//   ad_o       out  DATA_W  value driven onto AD
//   ad_oe      out  1       1 = drive AD from ad_o
//   ad_i       in   DATA_W  sampled AD value
//   ce_n       out  1       RAM port enable, active-low
//   we_n       out  1       RAM write enable, active-low
//   oe_n       out  1       RAM output enable, active-low
//
// Parameters
//   ADDR_W      address width (RAM depth 2**ADDR_W)
//   DATA_W      data width; equal to ADDR_W because AD is shared
//   ACCESS_CYC  cycles the WE_/OE_ strobe is held low (>= 1)
//   RECOV_CYC   cycles of recovery after each access (>= 1)
// -----------------------------------------------------------------------------
module dpram_bus_master #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int ACCESS_CYC = 2,
    parameter int RECOV_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [DATA_W-1:0] ad_o,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_i,
    output logic              ce_n,
    output logic              we_n,
    output logic              oe_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASETUP,
        S_ALATCH,
        S_WDATA,
        S_RTURN,
        S_RDATA,
        S_RECOV
    } state_t;

    // One shared counter times both the strobe phase and the recovery phase.
    localparam int MAX_CYC = (ACCESS_CYC > RECOV_CYC) ? ACCESS_CYC : RECOV_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] ACC_LAST   = CNT_W'(ACCESS_CYC - 1);
    localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(RECOV_CYC - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;

    logic              ce_n_reg, ce_n_next;
    logic              we_n_reg, we_n_next;
    logic              oe_n_reg, oe_n_next;
    logic              ad_oe_reg, ad_oe_next;
    logic [DATA_W-1:0] ad_o_reg, ad_o_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;

    logic              accept;

    assign req_ready = (state_reg == S_IDLE);
    assign accept    = req_valid && req_ready;

    // Next state, counter and request capture.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;

        // The capture values are forwarded so the address can be decoded onto
        // ad_o on the same edge that accepts the request.
        if (accept) begin
            we_next    = req_we;
            addr_next  = req_addr;
            wdata_next = req_wdata;
        end

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_ASETUP;
                end
            end
            S_ASETUP: begin
                state_next = S_ALATCH;
            end
            S_ALATCH: begin
                cnt_next   = '0;
                state_next = we_reg ? S_WDATA : S_RTURN;
            end
            S_RTURN: begin
                cnt_next   = '0;
                state_next = S_RDATA;
            end
            S_WDATA, S_RDATA: begin
                if (cnt_reg == ACC_LAST) begin
                    cnt_next   = '0;
                    state_next = S_RECOV;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_RECOV: begin
                if (cnt_reg == RECOV_LAST) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Pin decode from the next state so the pins switch on the same edge as
    // the state register. ad_o keeps its last value while the bus is released.
    always_comb begin
        ce_n_next  = 1'b1;
        we_n_next  = 1'b1;
        oe_n_next  = 1'b1;
        ad_oe_next = 1'b0;
        ad_o_next  = ad_o_reg;

        case (state_next)
            S_ASETUP: begin
                ad_oe_next = 1'b1;
                ad_o_next  = addr_next;
            end
            S_ALATCH: begin
                ad_oe_next = 1'b1;
                ad_o_next  = addr_next;
                ce_n_next  = 1'b0;
            end
            S_WDATA: begin
                ad_oe_next = 1'b1;
                ad_o_next  = wdata_next;
                ce_n_next  = 1'b0;
                we_n_next  = 1'b0;
            end
            S_RTURN: begin
                // Bus already released, RAM not yet driving: turnaround gap.
                ce_n_next = 1'b0;
            end
            S_RDATA: begin
                ce_n_next = 1'b0;
                oe_n_next = 1'b0;
            end
            default: begin
            end
        endcase

        // Pulse only on the first recovery cycle.
        rsp_valid_next = (state_next == S_RECOV) && (state_reg != S_RECOV);

        // Sample the bus on the edge that ends the read strobe phase.
        rsp_rdata_next = rsp_rdata_reg;
        if ((state_reg == S_RDATA) && (state_next == S_RECOV)) begin
            rsp_rdata_next = ad_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            ce_n_reg      <= 1'b1;
            we_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            ad_oe_reg     <= 1'b0;
            ad_o_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            ce_n_reg      <= ce_n_next;
            we_n_reg      <= we_n_next;
            oe_n_reg      <= oe_n_next;
            ad_oe_reg     <= ad_oe_next;
            ad_o_reg      <= ad_o_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

    assign ce_n      = ce_n_reg;
    assign we_n      = we_n_reg;
    assign oe_n      = oe_n_reg;
    assign ad_oe     = ad_oe_reg;
    assign ad_o      = ad_o_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_dpram_bus_master.sv
// -----------------------------------------------------------------------------
// tb_dpram_bus_master
//
// Directed bench for dpram_bus_master. Instance u_dut uses the default timing
// and talks to a small behavioural RAM; instance u_dut2 uses ACCESS_CYC=4,
// RECOV_CYC=2 against a RAM holding 0x5A at 0xFF. Cycle numbers count from
// the accept edge as cycle 0; outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_dpram_bus_master;

    logic       clk = 1'b0;
    logic       rst_n;

    // Default-timing instance
    logic       req_valid, req_ready, req_we;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata, ad_o, ad_i;
    logic       ad_oe, ce_n, we_n, oe_n;

    // Long-timing instance
    logic       req_valid2, req_ready2, req_we2;
    logic [7:0] req_addr2, req_wdata2;
    logic       rsp_valid2;
    logic [7:0] rsp_rdata2, ad_o2, ad_i2;
    logic       ad_oe2, ce_n2, we_n2, oe_n2;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    dpram_bus_master u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ad_o(ad_o), .ad_oe(ad_oe), .ad_i(ad_i),
        .ce_n(ce_n), .we_n(we_n), .oe_n(oe_n)
    );

    dpram_bus_master #(.ACCESS_CYC(4), .RECOV_CYC(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
        .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
        .ad_o(ad_o2), .ad_oe(ad_oe2), .ad_i(ad_i2),
        .ce_n(ce_n2), .we_n(we_n2), .oe_n(oe_n2)
    );

    // Behavioural RAM for u_dut: address latched on ce_n falling, data written
    // on each clock edge with we_n low, read data driven while oe_n is low.
    logic [7:0] mem1 [0:255];
    logic [7:0] lat1 = 8'h00;
    always @(negedge ce_n) lat1 = ad_o;
    always @(posedge clk) if (!ce_n && !we_n && ad_oe) mem1[lat1] <= ad_o;
    assign ad_i = !oe_n ? mem1[lat1] : 8'h00;

    // RAM for u_dut2: only location 0xFF holds data.
    logic [7:0] lat2 = 8'h00;
    always @(negedge ce_n2) lat2 = ad_o2;
    assign ad_i2 = (!oe_n2 && lat2 == 8'hFF) ? 8'h5A : 8'h00;

    // Pin invariants, both instances, every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks = n_checks + 6;
            if (!we_n && !oe_n) begin
                n_fail++; $display("FAIL inv_we_oe dut1 t=%0t: we_n=%b oe_n=%b required not both 0", $time, we_n, oe_n);
            end
            if (ad_oe && !oe_n) begin
                n_fail++; $display("FAIL inv_contention dut1 t=%0t: ad_oe=%b oe_n=%b required not 1/0", $time, ad_oe, oe_n);
            end
            if ((!we_n || !oe_n) && ce_n) begin
                n_fail++; $display("FAIL inv_strobe_ce dut1 t=%0t: ce_n=%b with we_n=%b oe_n=%b", $time, ce_n, we_n, oe_n);
            end
            if (!we_n2 && !oe_n2) begin
                n_fail++; $display("FAIL inv_we_oe dut2 t=%0t: we_n=%b oe_n=%b required not both 0", $time, we_n2, oe_n2);
            end
            if (ad_oe2 && !oe_n2) begin
                n_fail++; $display("FAIL inv_contention dut2 t=%0t: ad_oe=%b oe_n=%b required not 1/0", $time, ad_oe2, oe_n2);
            end
            if ((!we_n2 || !oe_n2) && ce_n2) begin
                n_fail++; $display("FAIL inv_strobe_ce dut2 t=%0t: ce_n=%b with we_n=%b oe_n=%b", $time, ce_n2, we_n2, oe_n2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on u_dut and wait (bounded) for its response and idle.
    task automatic do_access(input logic we, input logic [7:0] a, input logic [7:0] d,
                             output logic [7:0] rd, output int lat);
        lat = -1;
        rd  = 8'h00;
        req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (rsp_valid) begin
                lat = c;
                rd  = rsp_rdata;
                break;
            end
            tick();
        end
        for (int c = 0; c < 10 && !req_ready; c++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({req_ready, ce_n, we_n, oe_n, ad_oe, rsp_valid} !== 6'b111100) begin
            n_fail++; $display("FAIL reset_pins: got %b required 111100 (ready,ce_n,we_n,oe_n,ad_oe,rsp_valid)",
                               {req_ready, ce_n, we_n, oe_n, ad_oe, rsp_valid});
        end
        n_checks++;
        if (ad_o !== 8'h00 || rsp_rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: ad_o=%h rsp_rdata=%h required 00/00", ad_o, rsp_rdata);
        end
        n_checks++;
        if ({req_ready2, ce_n2, we_n2, oe_n2, ad_oe2, rsp_valid2} !== 6'b111100) begin
            n_fail++; $display("FAIL reset_pins2: got %b required 111100",
                               {req_ready2, ce_n2, we_n2, oe_n2, ad_oe2, rsp_valid2});
        end
        #2 rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_write();
        // bit index = cycle number (1..6)
        logic [7:0] e_ce, e_we, e_oe, e_adoe, e_rsp, e_rdy;
        logic [7:0] exp_ad;
        e_ce = 8'b01100010; e_we = 8'b01100110; e_oe = 8'b01111110;
        e_adoe = 8'b00011110; e_rsp = 8'b00100000; e_rdy = 8'b01000000;
        req_we = 1'b1; req_addr = 8'h3C; req_wdata = 8'hA5; req_valid = 1'b1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL write_ready_c0: got %b required 1", req_ready);
        end
        tick();
        req_valid = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) tick();
            n_checks++;
            if ({ce_n, we_n, oe_n, ad_oe, rsp_valid, req_ready} !==
                {e_ce[c], e_we[c], e_oe[c], e_adoe[c], e_rsp[c], e_rdy[c]}) begin
                n_fail++; $display("FAIL write_pins c%0d: got %b required %b (ce_n,we_n,oe_n,ad_oe,rsp,ready)", c,
                                   {ce_n, we_n, oe_n, ad_oe, rsp_valid, req_ready},
                                   {e_ce[c], e_we[c], e_oe[c], e_adoe[c], e_rsp[c], e_rdy[c]});
            end
            if (c <= 4) begin
                exp_ad = (c <= 2) ? 8'h3C : 8'hA5;
                n_checks++;
                if (ad_o !== exp_ad) begin
                    n_fail++; $display("FAIL write_ad_o c%0d: got %h required %h", c, ad_o, exp_ad);
                end
            end
        end
        $display("test_write 3C<-A5 done");
    endtask

    task automatic test_read();
        logic [7:0] e_ce, e_we, e_oe, e_adoe, e_rsp, e_rdy;
        e_ce = 8'b11000010; e_we = 8'b11111110; e_oe = 8'b11001110;
        e_adoe = 8'b00000110; e_rsp = 8'b01000000; e_rdy = 8'b10000000;
        req_we = 1'b0; req_addr = 8'h3C; req_wdata = 8'h00; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; req_addr = 8'h00;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) tick();
            n_checks++;
            if ({ce_n, we_n, oe_n, ad_oe, rsp_valid, req_ready} !==
                {e_ce[c], e_we[c], e_oe[c], e_adoe[c], e_rsp[c], e_rdy[c]}) begin
                n_fail++; $display("FAIL read_pins c%0d: got %b required %b (ce_n,we_n,oe_n,ad_oe,rsp,ready)", c,
                                   {ce_n, we_n, oe_n, ad_oe, rsp_valid, req_ready},
                                   {e_ce[c], e_we[c], e_oe[c], e_adoe[c], e_rsp[c], e_rdy[c]});
            end
            if (c == 6) begin
                n_checks++;
                if (rsp_rdata !== 8'hA5) begin
                    n_fail++; $display("FAIL read_rdata: got %h required A5", rsp_rdata);
                end
            end
        end
        $display("test_read 3C done");
    endtask

    task automatic test_back_to_back();
        logic       t_we   [3];
        logic [7:0] t_addr [3];
        logic [7:0] t_data [3];
        int acc [3];
        int accepts, rsps;
        logic [7:0] last_rd;
        logic took;
        t_we[0] = 1'b1; t_addr[0] = 8'h10; t_data[0] = 8'h11;
        t_we[1] = 1'b1; t_addr[1] = 8'h20; t_data[1] = 8'h22;
        t_we[2] = 1'b0; t_addr[2] = 8'h10; t_data[2] = 8'h00;
        accepts = 0; rsps = 0; last_rd = 8'h00;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        req_we = t_we[0]; req_addr = t_addr[0]; req_wdata = t_data[0]; req_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            took = 1'b0;
            if (rsp_valid) begin
                rsps++;
                last_rd = rsp_rdata;
            end
            if (req_valid && req_ready) begin
                if (accepts < 3) acc[accepts] = c;
                accepts++;
                took = 1'b1;
            end
            tick();
            if (took) begin
                if (accepts < 3) begin
                    req_we = t_we[accepts]; req_addr = t_addr[accepts]; req_wdata = t_data[accepts];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        n_checks++;
        if (accepts != 3) begin
            n_fail++; $display("FAIL b2b_accepts: got %0d required 3", accepts);
        end
        n_checks++;
        if (acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6) begin
            n_fail++; $display("FAIL b2b_interval: got %0d,%0d required 6,6", acc[1] - acc[0], acc[2] - acc[1]);
        end
        n_checks++;
        if (rsps != 3) begin
            n_fail++; $display("FAIL b2b_responses: got %0d required 3", rsps);
        end
        n_checks++;
        if (last_rd !== 8'h11) begin
            n_fail++; $display("FAIL b2b_read_data: got %h required 11", last_rd);
        end
        n_checks++;
        if (mem1[8'h20] !== 8'h22) begin
            n_fail++; $display("FAIL b2b_ram_20: got %h required 22", mem1[8'h20]);
        end
        $display("test_back_to_back done: %0d accepts, %0d responses", accepts, rsps);
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] rd;
        int lat;
        int rsp_seen;
        req_we = 1'b1; req_addr = 8'h40; req_wdata = 8'h77; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();             // now in cycle 4, second WDATA cycle
        n_checks++;
        if (we_n !== 1'b0 || ce_n !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_pre: we_n=%b ce_n=%b required 0/0", we_n, ce_n);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({we_n, ce_n, ad_oe, oe_n, req_ready} !== 5'b11011) begin
            n_fail++; $display("FAIL rstmid_async: got %b required 11011 (we_n,ce_n,ad_oe,oe_n,ready)",
                               {we_n, ce_n, ad_oe, oe_n, req_ready});
        end
        rsp_seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (rsp_valid) rsp_seen++;
        end
        #2 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rsp_valid) rsp_seen++;
        end
        n_checks++;
        if (rsp_seen != 0) begin
            n_fail++; $display("FAIL rstmid_no_rsp: got %0d pulses required 0", rsp_seen);
        end
        do_access(1'b1, 8'h41, 8'h99, rd, lat);
        n_checks++;
        if (lat != 5) begin
            n_fail++; $display("FAIL rstmid_write_latency: got %0d required 5", lat);
        end
        do_access(1'b0, 8'h41, 8'h00, rd, lat);
        n_checks++;
        if (lat != 6 || rd !== 8'h99) begin
            n_fail++; $display("FAIL rstmid_read: latency %0d data %h required 6 / 99", lat, rd);
        end
        $display("test_reset_mid_access done");
    endtask

    task automatic test_long_access();
        int first_oe, oe_cnt, rsp_cyc, rsp_cnt, first_rdy;
        logic [7:0] rd;
        first_oe = -1; oe_cnt = 0; rsp_cyc = -1; rsp_cnt = 0; first_rdy = -1; rd = 8'h00;
        req_we2 = 1'b0; req_addr2 = 8'hFF; req_wdata2 = 8'h00; req_valid2 = 1'b1;
        n_checks++;
        if (req_ready2 !== 1'b1) begin
            n_fail++; $display("FAIL long_ready_c0: got %b required 1", req_ready2);
        end
        tick();
        req_valid2 = 1'b0; req_addr2 = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) tick();
            if (!oe_n2) begin
                oe_cnt++;
                if (first_oe < 0) first_oe = c;
            end
            if (rsp_valid2) begin
                rsp_cnt++;
                rsp_cyc = c;
                rd = rsp_rdata2;
            end
            if (req_ready2 && first_rdy < 0) first_rdy = c;
        end
        n_checks++;
        if (oe_cnt != 4 || first_oe != 4) begin
            n_fail++; $display("FAIL long_oe: %0d cycles from c%0d required 4 from c4", oe_cnt, first_oe);
        end
        n_checks++;
        if (rsp_cnt != 1 || rsp_cyc != 8) begin
            n_fail++; $display("FAIL long_rsp: %0d pulses last c%0d required 1 at c8", rsp_cnt, rsp_cyc);
        end
        n_checks++;
        if (rd !== 8'h5A) begin
            n_fail++; $display("FAIL long_rdata: got %h required 5A", rd);
        end
        n_checks++;
        if (first_rdy != 10) begin
            n_fail++; $display("FAIL long_ready_back: got c%0d required c10", first_rdy);
        end
        $display("test_long_access FF done");
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = 8'h00; req_wdata2 = 8'h00;
        mon_en = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_access();
        test_long_access();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
